reg_status_file: RTL and testbench

Parameterised architectural register file with per-register rename status (busy bit plus ROB tag) for the Tomasulo/ROB core. Sits between decoder, ROB and fetcher. Serves N combinational operand read ports and takes one rename write per cycle from decode and one commit write per cycle from the ROB. Also supports a full flush on misbranch, optional commit-to-read bypass, and a registered count of busy registers for issue throttling.

---
 rtl/reg_status_file_if.sv | 36 +++
 rtl/reg_status_file.sv | 108 ++++++++++
 tb/tb_reg_status_file.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reg_status_file_if.sv
// Bundles the decode read ports, rename, commit and flush signals of reg_status_file.
// The master modport is the decoder/ROB side and the slave modport is the register file.
interface reg_status_file_if #(
   parameter int NREG     = 32,
   parameter int DATA_W   = 32,
   parameter int TAG_W    = 4,
   parameter int RD_PORTS = 2
);
   localparam int AW = $clog2(NREG);

   logic [RD_PORTS*AW-1:0]     in_rd_addr;
   logic [RD_PORTS*DATA_W-1:0] out_rd_value;
   logic [RD_PORTS*TAG_W-1:0]  out_rd_tag;
   logic [RD_PORTS-1:0]        out_rd_busy;
   logic                       in_dst_en;
   logic [AW-1:0]              in_dst_reg;
   logic [TAG_W-1:0]           in_dst_tag;
   logic                       in_cmt_en;
   logic [AW-1:0]              in_cmt_reg;
   logic [TAG_W-1:0]           in_cmt_tag;
   logic [DATA_W-1:0]          in_cmt_value;
   logic                       in_flush;
   logic [AW:0]                out_busy_cnt;

   modport master (
      output in_rd_addr, in_dst_en, in_dst_reg, in_dst_tag,
             in_cmt_en, in_cmt_reg, in_cmt_tag, in_cmt_value, in_flush,
      input  out_rd_value, out_rd_tag, out_rd_busy, out_busy_cnt
   );

   modport slave (
      input  in_rd_addr, in_dst_en, in_dst_reg, in_dst_tag,
             in_cmt_en, in_cmt_reg, in_cmt_tag, in_cmt_value, in_flush,
      output out_rd_value, out_rd_tag, out_rd_busy, out_busy_cnt
   );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag) and busy count.
// Optional commit-to-read bypass is enabled by defining REG_STATUS_BYPASS_EN.
module reg_status_file #(
   parameter int NREG     = 32,
   parameter int DATA_W   = 32,
   parameter int TAG_W    = 4,
   parameter int RD_PORTS = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   reg_status_file_if.slave   bus
);
   localparam int AW = $clog2(NREG);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] values_q [NREG];
   logic [DATA_W-1:0] values_d [NREG];
   logic [TAG_W-1:0]  tags_q   [NREG];
   logic [TAG_W-1:0]  tags_d   [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            values_q[i] <= '0;
            tags_q[i]   <= '0;
         end
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         values_q <= values_d;
         tags_q   <= tags_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   // Commit-clear is applied first so rename and flush override it for busy/tag.
   always_comb begin
      values_d = values_q;
      tags_d   = tags_q;
      busy_d   = busy_q;
      if (rdy) begin
         if (bus.in_cmt_en && bus.in_cmt_reg != '0) begin
            values_d[bus.in_cmt_reg] = bus.in_cmt_value;
            if (busy_q[bus.in_cmt_reg] && tags_q[bus.in_cmt_reg] == bus.in_cmt_tag)
               busy_d[bus.in_cmt_reg] = 1'b0;
         end
         if (bus.in_flush) begin
            busy_d = '0;
            for (int unsigned i = 0; i < NREG; i++)
               tags_d[i] = '0;
         end else if (bus.in_dst_en && bus.in_dst_reg != '0) begin
            busy_d[bus.in_dst_reg] = 1'b1;
            tags_d[bus.in_dst_reg] = bus.in_dst_tag;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      for (int unsigned i = 1; i < NREG; i++)
         cnt_d = cnt_d + CW'(busy_d[i]);
   end

   logic [RD_PORTS*DATA_W-1:0] rd_value;
   logic [RD_PORTS*TAG_W-1:0]  rd_tag;
   logic [RD_PORTS-1:0]        rd_busy;
   logic [AW-1:0]              a;
   logic                       byp_v;

   assign byp_v = bus.in_cmt_en && rdy && !bus.in_flush;

   always_comb begin
      rd_value = '0;
      rd_tag   = '0;
      rd_busy  = '0;
      a        = '0;
      for (int unsigned p = 0; p < RD_PORTS; p++) begin
         a = bus.in_rd_addr[p*AW +: AW];
         if (a != '0) begin
            rd_value[p*DATA_W +: DATA_W] = values_q[a];
            rd_tag[p*TAG_W +: TAG_W]     = tags_q[a];
            rd_busy[p]                   = busy_q[a];
`ifdef REG_STATUS_BYPASS_EN
            if (byp_v && a == bus.in_cmt_reg) begin
               rd_value[p*DATA_W +: DATA_W] = bus.in_cmt_value;
               if (tags_q[a] == bus.in_cmt_tag)
                  rd_busy[p] = 1'b0;
            end
`endif
         end
      end
   end

`ifndef REG_STATUS_BYPASS_EN
   logic unused_byp;
   assign unused_byp = byp_v;
`endif

   assign bus.out_rd_value = rd_value;
   assign bus.out_rd_tag   = rd_tag;
   assign bus.out_rd_busy  = rd_busy;
   assign bus.out_busy_cnt = cnt_q;
endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: reset, rename/commit ordering, flush, r0, rdy freeze, bypass.
module tb_reg_status_file;
   localparam int NREG = 32, DATA_W = 32, TAG_W = 4, RD_PORTS = 2;
   localparam int AW = 5;

   logic clk, rst, rdy;
   int   vectors = 0;
   int   miscompares = 0;

   reg_status_file_if #(.NREG(NREG), .DATA_W(DATA_W), .TAG_W(TAG_W), .RD_PORTS(RD_PORTS)) bus ();

   reg_status_file #(.NREG(NREG), .DATA_W(DATA_W), .TAG_W(TAG_W), .RD_PORTS(RD_PORTS)) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input int p, input int r,
                          input logic [31:0] v, input logic [3:0] t, input logic b);
      bus.in_rd_addr[p*AW +: AW] = AW'(r);
      #1;
      chk({tag, ".value"}, 64'(bus.out_rd_value[p*DATA_W +: DATA_W]), 64'(v));
      chk({tag, ".tag"},   64'(bus.out_rd_tag[p*TAG_W +: TAG_W]),     64'(t));
      chk({tag, ".busy"},  64'(bus.out_rd_busy[p]),                   64'(b));
   endtask

   task automatic idle();
      bus.in_dst_en    = 1'b0;
      bus.in_dst_reg   = '0;
      bus.in_dst_tag   = '0;
      bus.in_cmt_en    = 1'b0;
      bus.in_cmt_reg   = '0;
      bus.in_cmt_tag   = '0;
      bus.in_cmt_value = '0;
      bus.in_flush     = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   task automatic rename(input int r, input int t);
      bus.in_dst_en  = 1'b1;
      bus.in_dst_reg = AW'(r);
      bus.in_dst_tag = TAG_W'(t);
   endtask

   task automatic commit(input int r, input int t, input logic [31:0] v);
      bus.in_cmt_en    = 1'b1;
      bus.in_cmt_reg   = AW'(r);
      bus.in_cmt_tag   = TAG_W'(t);
      bus.in_cmt_value = v;
   endtask

   initial begin
      rst = 1'b0;
      rdy = 1'b1;
      bus.in_rd_addr = '0;
      idle();
      #2;
      chk_reg("rst_r0", 0, 0, 32'h0, 4'h0, 1'b0);
      chk_reg("rst_r5", 1, 5, 32'h0, 4'h0, 1'b0);
      chk_reg("rst_r31", 0, 31, 32'h0, 4'h0, 1'b0);
      chk("rst_cnt", 64'(bus.out_busy_cnt), 64'd0);

      @(negedge clk);
      rst = 1'b1;
      rename(5, 3);
      tick();
      chk_reg("ren_r5", 0, 5, 32'h0, 4'd3, 1'b1);
      chk("ren_cnt", 64'(bus.out_busy_cnt), 64'd1);

      rename(5, 7);
      tick();
      commit(5, 3, 32'hAA);
      tick();
      chk_reg("stale_cmt", 1, 5, 32'hAA, 4'd7, 1'b1);
      chk("stale_cnt", 64'(bus.out_busy_cnt), 64'd1);
      commit(5, 7, 32'hBB);
      tick();
      chk_reg("match_cmt", 0, 5, 32'hBB, 4'd7, 1'b0);
      chk("match_cnt", 64'(bus.out_busy_cnt), 64'd0);

      rename(2, 1);
      tick();
      commit(2, 1, 32'h10);
      rename(2, 4);
      tick();
      chk_reg("same_cyc", 0, 2, 32'h10, 4'd4, 1'b1);
      chk("same_cnt", 64'(bus.out_busy_cnt), 64'd1);

      for (int r = 1; r < 32; r++) begin
         rename(r, r % 16);
         tick();
      end
      chk("full_cnt", 64'(bus.out_busy_cnt), 64'd31);
      rename(4, 9);
      tick();
      chk("full_retag_cnt", 64'(bus.out_busy_cnt), 64'd31);
      chk_reg("full_retag", 1, 4, 32'h0, 4'd9, 1'b1);

      bus.in_flush = 1'b1;
      commit(9, 9, 32'h55);
      rename(3, 9);
      tick();
      chk("flush_cnt", 64'(bus.out_busy_cnt), 64'd0);
      for (int r = 1; r < 32; r++) begin
         bus.in_rd_addr[0 +: AW] = AW'(r);
         #1;
         chk($sformatf("flush_busy_r%0d", r), 64'(bus.out_rd_busy[0]), 64'd0);
      end
      chk_reg("flush_r9", 1, 9, 32'h55, 4'd0, 1'b0);
      chk_reg("flush_r3", 0, 3, 32'h0, 4'd0, 1'b0);

      rename(0, 6);
      commit(0, 0, 32'hFF);
      tick();
      chk_reg("r0", 0, 0, 32'h0, 4'd0, 1'b0);
      chk("r0_cnt", 64'(bus.out_busy_cnt), 64'd0);

      rdy = 1'b0;
      rename(6, 5);
      commit(6, 0, 32'h66);
      tick();
      chk_reg("frz_r6", 1, 6, 32'h0, 4'd0, 1'b0);
      chk("frz_cnt", 64'(bus.out_busy_cnt), 64'd0);
      rdy = 1'b1;

      rename(8, 2);
      tick();
      commit(8, 2, 32'h77);
`ifdef REG_STATUS_BYPASS_EN
      chk_reg("byp_same", 0, 8, 32'h77, 4'd2, 1'b0);
`else
      chk_reg("byp_same", 0, 8, 32'h0, 4'd2, 1'b1);
`endif
      tick();
      chk_reg("byp_next", 0, 8, 32'h77, 4'd2, 1'b0);
      chk("byp_cnt", 64'(bus.out_busy_cnt), 64'd0);

      rename(10, 5);
      tick();
      commit(10, 6, 32'h12);
      tick();
      chk_reg("mis_r10", 1, 10, 32'h12, 4'd5, 1'b1);
      commit(11, 0, 32'h34);
      tick();
      chk_reg("nb_r11", 0, 11, 32'h34, 4'd0, 1'b0);
      chk("nb_cnt", 64'(bus.out_busy_cnt), 64'd1);

      #1;
      rst = 1'b0;
      chk_reg("async_r10", 1, 10, 32'h0, 4'd0, 1'b0);
      chk("async_cnt", 64'(bus.out_busy_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      rename(12, 1);
      tick();
      chk_reg("post_rst", 0, 12, 32'h0, 4'd1, 1'b1);
      chk("post_rst_cnt", 64'(bus.out_busy_cnt), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
